// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and datapath width.
package mem_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Big-endian lane handling: byte enables, store replication, misalign check, load select/extend.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]        req_size_i,
   input  logic [1:0]        req_off_i,
   input  logic [DATA_W-1:0] store_data_i,
   output logic [3:0]        be_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              misalign_o,
   input  logic [1:0]        ld_size_i,
   input  logic [1:0]        ld_off_i,
   input  logic              ld_se_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] ld_data_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Size 2'b11 falls into the word branch
   always_comb begin
      be_o       = 4'b1111;
      wdata_o    = store_data_i;
      misalign_o = 1'b0;
      case (req_size_i)
         SZ_BYTE: begin
            be_o    = 4'b1000 >> req_off_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         SZ_HALF: begin
            be_o       = req_off_i[1] ? 4'b0011 : 4'b1100;
            wdata_o    = {2{store_data_i[15:0]}};
            misalign_o = req_off_i[0];
         end
         default: misalign_o = |req_off_i;
      endcase
   end

   always_comb begin
      case (ld_off_i)
         2'd0:    ld_byte = rdata_i[31:24];
         2'd1:    ld_byte = rdata_i[23:16];
         2'd2:    ld_byte = rdata_i[15:8];
         default: ld_byte = rdata_i[7:0];
      endcase
      ld_half = ld_off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
      case (ld_size_i)
         SZ_BYTE: ld_data_o = {{24{ld_se_i & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data_o = {{16{ld_se_i & ld_half[15]}}, ld_half};
         default: ld_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ready data-memory FSM, upstream stall and MEM/WB result registers.
module mem_access_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exmem_valid,
   input  logic [1:0]        mem_size,
   input  logic              mem_se,
   input  logic              mem_rw,
   input  logic              mem_enable,
   input  logic              load_instr,
   input  logic              rf_enable,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [4:0]        dest_reg,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              memwb_valid,
   output logic              memwb_rf_enable,
   output logic              memwb_load_instr,
   output logic [4:0]        memwb_dest,
   output logic [DATA_W-1:0] memwb_data,
   output logic              misalign_err
);
   import mem_pkg::*;

   mem_state_e        state_q;
   logic              req_q, we_q, misalign_q;
   logic [3:0]        be_q;
   logic [DATA_W-1:0] wdata_q, alu_q;
   logic [1:0]        size_q;
   logic              se_q, rf_q, load_q;
   logic [4:0]        dest_q;

   logic              wb_valid_q, wb_rf_q, wb_load_q;
   logic [4:0]        wb_dest_q;
   logic [DATA_W-1:0] wb_data_q;

   logic [3:0]        be_d;
   logic [DATA_W-1:0] wdata_d, ld_data;
   logic              misalign, aligned_req;
   logic [ADDR_W-1:0] addr_full;

   mem_lane_align u_align (
      .req_size_i  (mem_size),
      .req_off_i   (alu_result[1:0]),
      .store_data_i(store_data),
      .be_o        (be_d),
      .wdata_o     (wdata_d),
      .misalign_o  (misalign),
      .ld_size_i   (size_q),
      .ld_off_i    (alu_q[1:0]),
      .ld_se_i     (se_q),
      .rdata_i     (dmem_rdata),
      .ld_data_o   (ld_data)
   );

   assign aligned_req = exmem_valid & mem_enable & ~misalign;
   assign mem_stall   = ((state_q == ST_IDLE) & aligned_req) |
                        ((state_q == ST_ACCESS) & ~dmem_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         misalign_q <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         alu_q      <= '0;
         size_q     <= '0;
         se_q       <= 1'b0;
         rf_q       <= 1'b0;
         load_q     <= 1'b0;
         dest_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_rf_q    <= 1'b0;
         wb_load_q  <= 1'b0;
         wb_dest_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               wb_valid_q <= exmem_valid;
               wb_rf_q    <= rf_enable;
               wb_load_q  <= load_instr;
               wb_dest_q  <= dest_reg;
               wb_data_q  <= alu_result;
               if (exmem_valid && mem_enable) begin
                  if (misalign) begin
                     wb_rf_q    <= 1'b0;
                     misalign_q <= 1'b1;
                  end else begin
                     // Bubble into WB while the access is outstanding
                     wb_valid_q <= 1'b0;
                     req_q      <= 1'b1;
                     we_q       <= mem_rw;
                     be_q       <= be_d;
                     wdata_q    <= wdata_d;
                     alu_q      <= alu_result;
                     size_q     <= mem_size;
                     se_q       <= mem_se;
                     rf_q       <= rf_enable;
                     load_q     <= load_instr;
                     dest_q     <= dest_reg;
                     state_q    <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               wb_valid_q <= 1'b0;
               if (dmem_ready) begin
                  req_q      <= 1'b0;
                  we_q       <= 1'b0;
                  wb_valid_q <= 1'b1;
                  wb_rf_q    <= rf_q;
                  wb_load_q  <= load_q;
                  wb_dest_q  <= dest_q;
                  wb_data_q  <= we_q ? alu_q : ld_data;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign addr_full        = ADDR_W'(alu_q);
   assign dmem_addr        = {addr_full[ADDR_W-1:2], 2'b00};
   assign dmem_req         = req_q;
   assign dmem_we          = we_q;
   assign dmem_be          = be_q;
   assign dmem_wdata       = wdata_q;
   assign memwb_valid      = wb_valid_q;
   assign memwb_rf_enable  = wb_rf_q;
   assign memwb_load_instr = wb_load_q;
   assign memwb_dest       = wb_dest_q;
   assign memwb_data       = wb_data_q;
   assign misalign_err     = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against an arithmetic big-endian memory-access model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        exmem_valid, mem_se, mem_rw, mem_enable, load_instr, rf_enable;
   logic [1:0]  mem_size;
   logic [31:0] alu_result, store_data, dmem_rdata;
   logic [4:0]  dest_reg;
   logic        dmem_ready;
   logic        mem_stall, dmem_req, dmem_we, memwb_valid, memwb_rf_enable;
   logic        memwb_load_instr, misalign_err;
   logic [31:0] dmem_addr, dmem_wdata, memwb_data;
   logic [3:0]  dmem_be;
   logic [4:0]  memwb_dest;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .exmem_valid(exmem_valid), .mem_size(mem_size),
      .mem_se(mem_se), .mem_rw(mem_rw), .mem_enable(mem_enable), .load_instr(load_instr),
      .rf_enable(rf_enable), .alu_result(alu_result), .store_data(store_data),
      .dest_reg(dest_reg), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .memwb_valid(memwb_valid),
      .memwb_rf_enable(memwb_rf_enable), .memwb_load_instr(memwb_load_instr),
      .memwb_dest(memwb_dest), .memwb_data(memwb_data), .misalign_err(misalign_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic se,
                                            input logic [1:0] off, input logic [31:0] w);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (w >> (8 * (3 - int'(off)))) & 32'hFF;
         if (se && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = (w >> (off[1] ? 0 : 16)) & 32'hFFFF;
         if (se && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'b00) return 4'(8 >> off);
      if (sz == 2'b01) return off[1] ? 4'h3 : 4'hC;
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
      if (sz == 2'b00) return 32'(sd[7:0]) * 32'h0101_0101;
      if (sz == 2'b01) return 32'(sd[15:0]) * 32'h0001_0001;
      return sd;
   endfunction

   // Present one instruction at posedge+1, serve memory after 'lat' wait cycles, check MEM/WB.
   task automatic do_op(input logic v, input logic [1:0] sz, input logic se, input logic rw,
                        input logic men, input logic ld, input logic rfe,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst,
                        input logic [31:0] word, input int unsigned lat);
      logic mis, acc;
      int   stalls;
      exmem_valid = v;  mem_size = sz;  mem_se = se;  mem_rw = rw;  mem_enable = men;
      load_instr  = ld; rf_enable = rfe; alu_result = alu; store_data = sd; dest_reg = dst;
      dmem_ready  = 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
      mis = v & men & ((sz == 2'b01 && alu[0]) || (sz[1] && alu[1:0] != 2'b00));
      acc = v & men & ~mis;
      #1;
      if (acc) begin
         stalls = 0;
         check("req_before", 32'(dmem_req), 32'd0);
         if (mem_stall) stalls++;
         @(posedge clk); #1;
         dmem_ready = 1'b0;
         check("req", 32'(dmem_req), 32'd1);
         check("we", 32'(dmem_we), 32'(rw));
         check("addr", dmem_addr, {alu[31:2], 2'b00});
         check("be", 32'(dmem_be), 32'(ref_be(sz, alu[1:0])));
         if (rw) check("wdata", dmem_wdata, ref_wdata(sz, sd));
         for (int unsigned c = 0; c < lat; c++) begin
            #1;
            if (mem_stall) stalls++;
            check("bubble", 32'(memwb_valid), 32'd0);
            check("req_hold", 32'(dmem_req), 32'd1);
            @(posedge clk); #1;
         end
         dmem_ready = 1'b1;
         dmem_rdata = word;
         #1;
         check("stall_ready", 32'(mem_stall), 32'd0);
         check("stall_cycles", 32'(stalls), 32'(lat + 1));
         @(posedge clk); #1;
         dmem_ready = 1'b0;
         check("wb_valid", 32'(memwb_valid), 32'd1);
         check("wb_rf", 32'(memwb_rf_enable), 32'(rfe));
         check("wb_load", 32'(memwb_load_instr), 32'(ld));
         check("wb_dest", 32'(memwb_dest), 32'(dst));
         check("wb_data", memwb_data, rw ? alu : ref_load(sz, se, alu[1:0], word));
         check("req_done", 32'(dmem_req), 32'd0);
         check("misalign_none", 32'(misalign_err), 32'd0);
      end else begin
         check("stall_pass", 32'(mem_stall), 32'd0);
         check("req_pass", 32'(dmem_req), 32'd0);
         @(posedge clk); #1;
         check("pass_valid", 32'(memwb_valid), 32'(v));
         check("pass_rf", 32'(memwb_rf_enable), 32'(mis ? 1'b0 : rfe));
         check("pass_load", 32'(memwb_load_instr), 32'(ld));
         check("pass_dest", 32'(memwb_dest), 32'(dst));
         check("pass_data", memwb_data, alu);
         check("misalign", 32'(misalign_err), 32'(mis));
         check("req_idle", 32'(dmem_req), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1;
      exmem_valid = 1'b0; mem_size = 2'b00; mem_se = 1'b0; mem_rw = 1'b0; mem_enable = 1'b0;
      load_instr = 1'b0; rf_enable = 1'b0; alu_result = '0; store_data = '0; dest_reg = '0;
      dmem_ready = 1'b0; dmem_rdata = '0;
      #12;
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_valid", 32'(memwb_valid), 32'd0);
      check("rst_data", memwb_data, 32'd0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      check("rst_be", 32'(dmem_be), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op(1, 2'b10, 0, 0, 0, 0, 1, 32'h1234_5678, 32'h0, 5'd7, 32'h0, 0);
      do_op(1, 2'b00, 1, 0, 1, 1, 1, 32'h0000_0103, 32'h0, 5'd5, 32'hAABB_CC80, 3);
      do_op(1, 2'b01, 0, 0, 1, 1, 1, 32'h0000_0102, 32'h0, 5'd6, 32'h8001_F00D, 1);
      do_op(1, 2'b00, 0, 1, 1, 0, 0, 32'h0000_0201, 32'hAB, 5'd0, 32'h0, 0);
      do_op(1, 2'b10, 0, 0, 1, 1, 1, 32'h0000_0006, 32'h0, 5'd9, 32'h0, 0);
      do_op(1, 2'b01, 1, 0, 1, 1, 1, 32'h0000_0011, 32'h0, 5'd3, 32'h0, 0);
      do_op(1, 2'b11, 1, 0, 1, 1, 1, 32'h0000_0040, 32'h0, 5'd4, 32'h8765_4321, 2);
      do_op(1, 2'b01, 1, 0, 1, 1, 1, 32'h0000_0040, 32'h0, 5'd8, 32'h9ABC_0001, 0);

      // Reset while an access is outstanding
      exmem_valid = 1'b1; mem_size = 2'b10; mem_rw = 1'b0; mem_enable = 1'b1;
      load_instr = 1'b1; rf_enable = 1'b1; alu_result = 32'h300; dest_reg = 5'd2;
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      exmem_valid = 1'b0;
      check("rst_mid_req_before", 32'(dmem_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("rst_mid_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      check("rst_mid_valid", 32'(memwb_valid), 32'd0);
      check("rst_mid_req_after", 32'(dmem_req), 32'd0);
      do_op(1, 2'b00, 0, 0, 0, 0, 1, 32'h0000_0055, 32'h0, 5'd1, 32'h0, 0);

      for (int i = 0; i < 60; i++) begin
         do_op(1'($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
               $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
